// File: rtl/systolic_data_setup.sv
// Diagonal skew feeder for the systolic array: row r is delayed r+1 advances, then zero-drained.
// Optional STALL_CNT output is enabled by defining SDS_STALL_CNT_EN.
module systolic_data_setup #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 256
) (
    input  logic                                  CLK,
    input  logic                                  SYNC_RST,
    input  logic                                  IN_VALID,
    output logic                                  IN_READY,
    input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  IN_DATA,
    input  logic                                  IN_LAST,
    input  logic                                  OUT_READY,
    output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  SKEWED,
    output logic                                  OUT_EN,
    output logic                                  DONE,
    output logic                                  BUSY
`ifdef SDS_STALL_CNT_EN
    ,
    output logic [31:0]                           STALL_CNT
`endif
);

    localparam int CW = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            advance;
    logic            done_nxt;
    logic            fill_zero;

    always_comb begin
        IN_READY  = !SYNC_RST && OUT_READY && (state == IDLE || state == STREAM);
        advance   = 1'b0;
        done_nxt  = 1'b0;
        fill_zero = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, STREAM: begin
                if (IN_VALID && IN_READY) begin
                    advance = 1'b1;
                    if (IN_LAST) begin
                        // a one-row array has nothing left to flush after the last vector
                        if (SA_LENGTH == 1) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = DRAIN;
                            cnt_nxt   = CW'(SA_LENGTH - 1);
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            DRAIN: begin
                fill_zero = 1'b1;
                if (OUT_READY) begin
                    advance = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state  <= IDLE;
            cnt    <= '0;
            OUT_EN <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            OUT_EN <= advance;
            DONE   <= done_nxt;
        end
    end

    assign BUSY = (state != IDLE);

    // Row r: chain[0] takes the new element, chain[r] drives the array input.
    for (genvar r = 0; r < SA_LENGTH; r++) begin : g_row
        logic [r:0][DATA_WIDTH-1:0] chain;
        logic [DATA_WIDTH-1:0]      row_in;

        assign row_in = fill_zero ? '0 : IN_DATA[r];

        always_ff @(posedge CLK) begin
            if (SYNC_RST) begin
                chain <= '0;
            end else if (advance) begin
                for (int unsigned k = r; k > 0; k--) begin
                    chain[k] <= chain[k-1];
                end
                chain[0] <= row_in;
            end
        end

        assign SKEWED[r] = chain[r];
    end

`ifdef SDS_STALL_CNT_EN
    logic stall_cycle;

    assign stall_cycle = (state != IDLE && !OUT_READY) || (state == STREAM && !IN_VALID);

    always_ff @(posedge CLK) begin
        if (SYNC_RST || DONE) begin
            STALL_CNT <= '0;
        end else if (stall_cycle && STALL_CNT != '1) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif

endmodule
